// File: rtl/jkff_pkg.sv
// Shared opcode/state types and default sizing for the JK flop bank sequencer.
package jkff_pkg;

  localparam int DEF_WIDTH     = 4;
  localparam int DEF_MAX_RETRY = 3;

  typedef enum logic [2:0] {
    OP_HOLD     = 3'd0,
    OP_SET_ALL  = 3'd1,
    OP_CLR_ALL  = 3'd2,
    OP_TOGGLE   = 3'd3,
    OP_LOAD     = 3'd4,
    OP_COUNT_UP = 3'd5,
    OP_COUNT_DN = 3'd6,
    OP_ILLEGAL  = 3'd7
  } jk_op_e;

  typedef enum logic [1:0] {
    ST_IDLE  = 2'd0,
    ST_DRIVE = 2'd1,
    ST_CHECK = 2'd2,
    ST_FIN   = 2'd3
  } jk_state_e;

endpackage

// File: rtl/jkff_bank_seq_jk_step_gen.sv
// Combinational J/K encoder for one bank step; COUNT_DN decode exists only
// when JKFF_BANK_SEQ_COUNT_DN_EN is defined.
module jk_step_gen
  import jkff_pkg::*;
#(
  parameter int WIDTH = DEF_WIDTH
) (
  input  logic [2:0]       op,
  input  logic [WIDTH-1:0] data,
  input  logic [WIDTH-1:0] q,
  output logic [WIDTH-1:0] j,
  output logic [WIDTH-1:0] k
);

  // Bit i toggles when every lower bit carries (up) or borrows (down).
  logic [WIDTH-1:0] t_up;
`ifdef JKFF_BANK_SEQ_COUNT_DN_EN
  logic [WIDTH-1:0] t_dn;
`endif

  always_comb begin
    t_up    = '0;
    t_up[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_up[i] = t_up[i-1] & q[i-1];
    end
  end

`ifdef JKFF_BANK_SEQ_COUNT_DN_EN
  always_comb begin
    t_dn    = '0;
    t_dn[0] = 1'b1;
    for (int i = 1; i < WIDTH; i++) begin
      t_dn[i] = t_dn[i-1] & ~q[i-1];
    end
  end
`endif

  always_comb begin
    j = '0;
    k = '0;
    case (jk_op_e'(op))
      OP_TOGGLE: begin
        j = data;
        k = data;
      end
      OP_LOAD: begin
        j = data;
        k = ~data;
      end
      OP_COUNT_UP: begin
        j = t_up;
        k = t_up;
      end
`ifdef JKFF_BANK_SEQ_COUNT_DN_EN
      OP_COUNT_DN: begin
        j = t_dn;
        k = t_dn;
      end
`endif
      default: ;
    endcase
  end

endmodule

// File: rtl/jkff_bank_seq.sv
// Command sequencer for a bank of JK flops: drive, read back, retry on mismatch.
// Optional COUNT_DN opcode enabled by defining JKFF_BANK_SEQ_COUNT_DN_EN.
//
// state    | meaning
// ---------+---------------------------------------------------------------
// ST_IDLE  | cmd_ready high, waiting for a command
// ST_DRIVE | j/k or set/clr asserted for the current step
// ST_CHECK | outputs quiet, q_in compared with the expected value
// ST_FIN   | one-cycle done or err pulse, then back to idle
module jkff_bank_seq
  import jkff_pkg::*;
#(
  parameter int WIDTH     = DEF_WIDTH,
  parameter int MAX_RETRY = DEF_MAX_RETRY
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             cmd_valid,
  output logic             cmd_ready,
  input  logic [2:0]       cmd_op,
  input  logic [WIDTH-1:0] cmd_data,
  input  logic [7:0]       cmd_len,
  output logic [WIDTH-1:0] jk_j,
  output logic [WIDTH-1:0] jk_k,
  output logic             ff_set,
  output logic             ff_clr,
  input  logic [WIDTH-1:0] q_in,
  output logic             done,
  output logic             err,
  output logic             busy
);

`ifdef JKFF_BANK_SEQ_COUNT_DN_EN
  localparam bit CNT_DN_EN = 1'b1;
`else
  localparam bit CNT_DN_EN = 1'b0;
`endif
  localparam logic [WIDTH-1:0] ONE = WIDTH'(1);

  jk_state_e        state;
  jk_op_e           op_r;
  logic [WIDTH-1:0] data_r;
  logic [WIDTH-1:0] cur_q;
  logic [WIDTH-1:0] exp_q;
  logic [7:0]       rem;
  logic [7:0]       retry_cnt;

  jk_op_e           op_in;
  logic             in_count;
  logic             in_illegal;
  logic [WIDTH-1:0] exp_in;
  logic [WIDTH-1:0] cur_next;
  logic [2:0]       step_op;
  logic [WIDTH-1:0] step_data;
  logic [WIDTH-1:0] step_q;
  logic [WIDTH-1:0] step_j;
  logic [WIDTH-1:0] step_k;
  logic             accept;

  assign op_in  = jk_op_e'(cmd_op);
  assign accept = cmd_valid && cmd_ready;

  always_comb begin
    in_count   = (op_in == OP_COUNT_UP) || (CNT_DN_EN && (op_in == OP_COUNT_DN));
    in_illegal = (op_in == OP_ILLEGAL) || (!CNT_DN_EN && (op_in == OP_COUNT_DN));
  end

  always_comb begin
    exp_in = q_in;
    case (op_in)
      OP_SET_ALL:  exp_in = '1;
      OP_CLR_ALL:  exp_in = '0;
      OP_TOGGLE:   exp_in = q_in ^ cmd_data;
      OP_LOAD:     exp_in = cmd_data;
      OP_COUNT_UP: exp_in = q_in + WIDTH'(cmd_len);
      OP_COUNT_DN: exp_in = q_in - WIDTH'(cmd_len);
      default:     exp_in = q_in;
    endcase
  end

  // The bank updates on the same edge the next step is registered, so count
  // steps are encoded from a tracked copy of q rather than the stale q_in.
  assign cur_next = (op_r == OP_COUNT_DN) ? (cur_q - ONE) : (cur_q + ONE);

  always_comb begin
    if (state == ST_IDLE) begin
      step_op   = cmd_op;
      step_data = cmd_data;
      step_q    = q_in;
    end else begin
      step_op   = op_r;
      step_data = data_r;
      step_q    = cur_next;
    end
  end

  jk_step_gen #(.WIDTH(WIDTH)) u_step_gen (
    .op   (step_op),
    .data (step_data),
    .q    (step_q),
    .j    (step_j),
    .k    (step_k)
  );

  always_ff @(posedge clk) begin
    if (!reset) begin
      state     <= ST_IDLE;
      op_r      <= OP_HOLD;
      data_r    <= '0;
      cur_q     <= '0;
      exp_q     <= '0;
      rem       <= '0;
      retry_cnt <= '0;
      jk_j      <= '0;
      jk_k      <= '0;
      ff_set    <= 1'b0;
      ff_clr    <= 1'b0;
      done      <= 1'b0;
      err       <= 1'b0;
      busy      <= 1'b0;
      cmd_ready <= 1'b0;
    end else begin
      jk_j   <= '0;
      jk_k   <= '0;
      ff_set <= 1'b0;
      ff_clr <= 1'b0;
      done   <= 1'b0;
      err    <= 1'b0;
      case (state)
        ST_IDLE: begin
          cmd_ready <= 1'b1;
          if (accept) begin
            cmd_ready <= 1'b0;
            busy      <= 1'b1;
            op_r      <= op_in;
            data_r    <= cmd_data;
            cur_q     <= q_in;
            exp_q     <= exp_in;
            retry_cnt <= '0;
            rem       <= '0;
            if (in_illegal) begin
              err   <= 1'b1;
              state <= ST_FIN;
            end else if (in_count && (cmd_len == 8'd0)) begin
              done  <= 1'b1;
              state <= ST_FIN;
            end else begin
              state <= ST_DRIVE;
              if (in_count) rem <= cmd_len - 8'd1;
              if (op_in == OP_SET_ALL) begin
                ff_set <= 1'b1;
              end else if (op_in == OP_CLR_ALL) begin
                ff_clr <= 1'b1;
              end else begin
                jk_j <= step_j;
                jk_k <= step_k;
              end
            end
          end
        end
        ST_DRIVE: begin
          if (rem != 8'd0) begin
            rem   <= rem - 8'd1;
            cur_q <= cur_next;
            jk_j  <= step_j;
            jk_k  <= step_k;
          end else begin
            state <= ST_CHECK;
          end
        end
        ST_CHECK: begin
          if (q_in == exp_q) begin
            done  <= 1'b1;
            state <= ST_FIN;
          end else if (retry_cnt < 8'(MAX_RETRY)) begin
            retry_cnt <= retry_cnt + 8'd1;
            rem       <= '0;
            jk_j      <= exp_q;
            jk_k      <= ~exp_q;
            state     <= ST_DRIVE;
          end else begin
            err   <= 1'b1;
            state <= ST_FIN;
          end
        end
        ST_FIN: begin
          busy      <= 1'b0;
          cmd_ready <= 1'b1;
          retry_cnt <= '0;
          state     <= ST_IDLE;
        end
        default: state <= ST_IDLE;
      endcase
    end
  end

endmodule
